// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, flag bit positions and default width shared by
// the ALU top level and its flag generator.
package alu_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [2:0] OP_SLA = 3'b000;
    localparam logic [2:0] OP_SRA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    localparam int FLAG_OVF  = 2;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_NEG  = 0;

endpackage

// File: rtl/alu_flags.sv
// alu_flags: combinational overflow / zero / negative generation from the
// operands, the wrapped result, the opcode and the multiply high half.
module alu_flags
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_res,
    input  logic [2:0]       i_opcode,
    input  logic [WIDTH-1:0] i_mul_hi,
    output logic [2:0]       o_flags
);

    logic w_ovf;

    // Signed overflow per opcode; logic ops and sra can never overflow
    always_comb begin
        w_ovf = 1'b0;
        case (i_opcode)
            OP_SLA: w_ovf = i_a[WIDTH-1] ^ i_a[WIDTH-2];
            OP_ADD: w_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                            (i_res[WIDTH-1] != i_a[WIDTH-1]);
            OP_SUB: w_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                            (i_res[WIDTH-1] != i_a[WIDTH-1]);
            // Product fits only if the high half is the sign-extension of the low half
            OP_MUL: w_ovf = (i_mul_hi != {WIDTH{i_res[WIDTH-1]}});
            default: w_ovf = 1'b0;
        endcase
    end

    assign o_flags[FLAG_OVF]  = w_ovf;
    assign o_flags[FLAG_ZERO] = (i_res == '0);
    assign o_flags[FLAG_NEG]  = i_res[WIDTH-1];

endmodule

// File: rtl/alu.sv
// alu: registered 32-bit execute-stage ALU (shift, add, sub, mul, and, or,
// not) with overflow/zero/negative flags and one cycle of latency.
// Build option: define ALU_MUL_EN to synthesize the signed multiplier; when
// undefined, opcode 100 returns c=0 with only the zero flag set.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] c,
    output logic [2:0]       d,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_mul_hi;
    logic [2:0]       w_flags;

    logic [WIDTH-1:0] r_c;
    logic [2:0]       r_d;
    logic             r_vld;

`ifdef ALU_MUL_EN
    logic signed [2*WIDTH-1:0] w_a_ext;
    logic signed [2*WIDTH-1:0] w_b_ext;
    logic signed [2*WIDTH-1:0] w_product;

    // Sign-extend both operands so the full double-width product is exact
    assign w_a_ext   = $signed({{WIDTH{a[WIDTH-1]}}, a});
    assign w_b_ext   = $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign w_product = w_a_ext * w_b_ext;
`endif

    // Operation mux producing the wrapped result and, for mul, the high half
    always_comb begin
        w_result = '0;
        w_mul_hi = '0;
        case (opcode)
            OP_SLA: w_result = {a[WIDTH-2:0], 1'b0};
            OP_SRA: w_result = {a[WIDTH-1], a[WIDTH-1:1]};
            OP_ADD: w_result = a + b;
            OP_SUB: w_result = a - b;
            OP_MUL: begin
`ifdef ALU_MUL_EN
                w_result = w_product[WIDTH-1:0];
                w_mul_hi = w_product[2*WIDTH-1:WIDTH];
`else
                w_result = '0;
                w_mul_hi = '0;
`endif
            end
            OP_AND: w_result = a & b;
            OP_OR:  w_result = a | b;
            OP_NOT: w_result = ~a;
            default: w_result = '0;
        endcase
    end

    alu_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .i_a      (a),
        .i_b      (b),
        .i_res    (w_result),
        .i_opcode (opcode),
        .i_mul_hi (w_mul_hi),
        .o_flags  (w_flags)
    );

    // Output registers: capture on in_valid, hold otherwise; reset discards in-flight work
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c   <= '0;
            r_d   <= '0;
            r_vld <= 1'b0;
        end else begin
            r_vld <= in_valid;
            if (in_valid) begin
                r_c <= w_result;
                r_d <= w_flags;
            end
        end
    end

    assign c         = r_c;
    assign d         = r_d;
    assign out_valid = r_vld;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and randomized checks of the alu against a signed
// integer reference model.
module tb_alu;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    opcode;
    logic [W-1:0]  c;
    logic [2:0]    d;
    logic          out_valid;

    int n_checks;
    int n_fail;

    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .c         (c),
        .d         (d),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed integer arithmetic in 64 bits, overflow = out of int32 range
    function automatic logic [34:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint   sx;
        longint   sy;
        longint   r;
        logic     ovf;
        logic [31:0] res;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        r   = 0;
        ovf = 1'b0;
        res = '0;
        case (op)
            3'd0: begin r = sx * 2;  res = r[31:0]; ovf = (r > MAXI) || (r < MINI); end
            3'd1: begin r = sx >>> 1; res = r[31:0]; end
            3'd2: begin r = sx + sy; res = r[31:0]; ovf = (r > MAXI) || (r < MINI); end
            3'd3: begin r = sx - sy; res = r[31:0]; ovf = (r > MAXI) || (r < MINI); end
            3'd4: begin
`ifdef ALU_MUL_EN
                r = sx * sy; res = r[31:0]; ovf = (r > MAXI) || (r < MINI);
`else
                res = '0;
`endif
            end
            3'd5: res = x & y;
            3'd6: res = x | y;
            default: res = ~x;
        endcase
        return {ovf, (res == 32'd0), res[31], res};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one operation and check the registered result one cycle later
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [34:0] e;
        e        = model(op, x, y);
        opcode   = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".c"},   c, e[31:0]);
        check({tag, ".d"},   {29'd0, d}, {29'd0, e[34:32]});
        check({tag, ".vld"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic check_fixed(input string tag, input logic [31:0] ec, input logic [2:0] ed);
        check({tag, ".fc"}, c, ec);
        check({tag, ".fd"}, {29'd0, d}, {29'd0, ed});
    endtask

    logic [31:0] held_c;
    logic [2:0]  held_d;
    logic [31:0] sp [8];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a = '0; b = '0; opcode = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.c", c, 32'd0);
        check("rst.d", {29'd0, d}, 32'd0);
        check("rst.vld", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        run_op("sla1", 3'd0, 32'hC29B2CC1, 32'h0);
        check_fixed("sla1", 32'h85365982, 3'b001);
        run_op("sla2", 3'd0, 32'h829B2CC1, 32'h0);
        check_fixed("sla2", 32'h05365982, 3'b100);
        run_op("sra", 3'd1, 32'h80000003, 32'h0);
        check_fixed("sra", 32'hC0000001, 3'b001);
        run_op("add_ovf", 3'd2, 32'h929B2CC1, 32'h82D23212);
        check_fixed("add_ovf", 32'h156D5ED3, 3'b100);
        run_op("add_max", 3'd2, 32'h7FFFFFFF, 32'h00000001);
        check_fixed("add_max", 32'h80000000, 3'b101);
        run_op("sub_ovf", 3'd3, 32'h82000000, 32'h3FFFFFFF);
        check_fixed("sub_ovf", 32'h42000001, 3'b100);
        run_op("sub_zero", 3'd3, 32'h529B2CC1, 32'h529B2CC1);
        check_fixed("sub_zero", 32'h0, 3'b010);
        run_op("sub_ovf2", 3'd3, 32'h82000000, 32'h02000001);
        check_fixed("sub_ovf2", 32'h7FFFFFFF, 3'b100);
        run_op("and", 3'd5, 32'hC29B2CC1, 32'hD2D23212);
        check_fixed("and", 32'hC2922000, 3'b001);
        run_op("or0", 3'd6, 32'h0, 32'h0);
        check_fixed("or0", 32'h0, 3'b010);
        run_op("not", 3'd7, 32'hFFFFFFFF, 32'h12345678);
        check_fixed("not", 32'h0, 3'b010);
`ifdef ALU_MUL_EN
        run_op("mul_wrap", 3'd4, 32'h00010000, 32'h00010000);
        check_fixed("mul_wrap", 32'h0, 3'b110);
        run_op("mul_neg", 3'd4, 32'hFFFFFFFF, 32'h00000005);
        check_fixed("mul_neg", 32'hFFFFFFFB, 3'b001);
`else
        run_op("mul_off", 3'd4, 32'h00010000, 32'h00010000);
        check_fixed("mul_off", 32'h0, 3'b010);
`endif

        // Hold: idle cycle keeps c/d and drops out_valid
        held_c   = c;
        held_d   = d;
        in_valid = 1'b0;
        a = 32'hDEADBEEF; b = 32'h1; opcode = 3'd2;
        @(posedge clk);
        #1;
        check("hold.c", c, held_c);
        check("hold.d", {29'd0, d}, {29'd0, held_d});
        check("hold.vld", {31'd0, out_valid}, 32'd0);

        // Randomized back-to-back stream with boundary operands mixed in
        sp[0] = 32'h0;        sp[1] = 32'hFFFFFFFF; sp[2] = 32'h7FFFFFFF; sp[3] = 32'h80000000;
        sp[4] = 32'h1;        sp[5] = 32'h40000000; sp[6] = 32'hC0000000; sp[7] = 32'h0000FFFF;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 7)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 7)] : $urandom;
            run_op("rand", 3'($urandom_range(0, 7)), ra, rb);
        end

        // Reset mid-stream: in-flight operation discarded, outputs clear immediately
        opcode   = 3'd7;
        a        = 32'h0;
        in_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst.c", c, 32'd0);
        check("arst.d", {29'd0, d}, 32'd0);
        check("arst.vld", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("arst_edge.c", c, 32'd0);
        check("arst_edge.vld", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst.c", c, 32'd0);
        check("post_rst.d", {29'd0, d}, 32'd0);
        check("post_rst.vld", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion, expected finish within bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Registered 32-bit integer ALU with eight operations selected by a 3-bit opcode: shifts, add, subtract, multiply, AND, OR and NOT.
- Produces a 32-bit result and a 3-bit status flag vector, both registered, one cycle after the operands are sampled.
- Used as the execute-stage arithmetic unit of the processor datapath.

Parameters:
- WIDTH, 32, operand and result width. All flag rules below are stated in terms of WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  when high, a, b and opcode are sampled on this clock edge.
- a  input  WIDTH  operand A; the only operand for the shift and NOT operations.
- b  input  WIDTH  operand B; ignored for sla, sra and not.
- opcode  input  3  operation select.
- c  output  WIDTH  registered result.
- d  output  3  registered flags: d[2]=overflow, d[1]=zero, d[0]=negative.
- out_valid  output  1  high for one cycle when c and d hold a new result.

Behaviour:
- Opcode encoding (package constants):
  - 000 sla: arithmetic left shift of a by 1.
  - 001 sra: arithmetic right shift of a by 1.
  - 010 add
  - 011 sub
  - 100 mul
  - 101 and
  - 110 or
  - 111 not: bitwise ~a.
- Reset: while rst_n is low, c=0, d=0 and out_valid=0, applied immediately and independent of clk. An operation in flight when reset asserts is discarded.
- Latency: one cycle.
  - A posedge with in_valid=1 registers c, d and sets out_valid=1.
  - A posedge with in_valid=0 holds c and d and clears out_valid.
  - No backpressure; back-to-back inputs give back-to-back results.
- sla: c = {a[WIDTH-2:0],1'b0}. Overflow = a[WIDTH-1] ^ a[WIDTH-2] (sign changed).
- sra: c = {a[WIDTH-1],a[WIDTH-1:1]}. Overflow = 0.
- add: c = (a+b) mod 2^WIDTH. Overflow = operands have the same sign and the result sign differs.
- sub: c = (a-b) mod 2^WIDTH. Overflow = operands have different signs and the result sign differs from a.
- mul: signed a*b, c = low WIDTH bits of the product. Overflow = 1 when the full signed 2·WIDTH product is not the sign-extension of c.
- and/or/not: bitwise. Overflow = 0.
- Zero flag d[1] = (c == 0), from the wrapped result, for every opcode.
- Negative flag d[0] = c[WIDTH-1] for every opcode.
- Overflow and zero may both be set, e.g. a wrapped mul whose low bits are 0.
- No carry output; unsigned wrap is not flagged.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: opcode 100 implements the signed multiply described above.
- Undefined: no multiplier is synthesized. Opcode 100 gives c=0, d=3'b010 (zero flag set, overflow 0, negative 0).

Decomposition:
- Package alu_pkg holds the opcode localparams (OP_SLA … OP_NOT), the flag bit indices (FLAG_OVF=2, FLAG_ZERO=1, FLAG_NEG=0) and the WIDTH default.
- One sub-module, alu_flags: combinational generation of overflow, zero and negative from a, b, the raw result, the opcode and the multiply high half.
- The top level holds the operation mux and the output registers.

Test Plan:
- Reset: rst_n=0 mid-stream -> c=0, d=0, out_valid=0 immediately. After release with in_valid=0 the outputs stay 0.
- sla:
  - a=0xC29B2CC1 -> c=0x85365982, d=3'b001.
  - a=0x829B2CC1 -> c=0x05365982, d=3'b100.
- add/sub overflow:
  - add 0x929B2CC1+0x82D23212 -> c=0x156D5ED3, d=3'b100.
  - sub 0x82000000-0x3FFFFFFF -> c=0x42000001, d=3'b100.
- sub zero: a=b=0x529B2CC1 -> c=0, d=3'b010. Also sub 0x82000000-0x02000001 -> c=0x7FFFFFFF, d=3'b100.
- Logic:
  - and 0xC29B2CC1&0xD2D23212 -> c=0xC2922000, d=3'b001.
  - or 0|0 -> c=0, d=3'b010.
  - not 0xFFFFFFFF -> c=0, d=3'b010.
- mul (ALU_MUL_EN defined):
  - 0x00010000*0x00010000 -> c=0, d=3'b110.
  - 0xFFFFFFFF*0x00000005 -> c=0xFFFFFFFB, d=3'b001.
  - Back-to-back in_valid gives one result per cycle with out_valid continuously high.
